// File: rtl/ins_dispatch_pkg.sv
// ins_dispatch_pkg: global widths, opcodes, instruction field positions and dispatcher FSM states
package GLOBAL_PARAM;
  localparam int INST_W = 32;
endpackage

package INS_CONST;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_LOAD = 4'd1;
  localparam logic [OP_W-1:0] OP_CALC = 4'd2;
  localparam logic [OP_W-1:0] OP_SWITCH = 4'd3;
  localparam int MODE_LSB = 0;
  localparam int IDX_LSB = 3;
  localparam int TRIP_LSB = 11;
  localparam int NEW_BIT = 19;
  localparam int PAD_LSB = 20;
  localparam int CUT_BIT = 24;
  localparam int SEL_D = 0;
  localparam int SEL_P = 1;
  localparam int SEL_I = 2;
  localparam int SEL_A = 3;
  localparam int SEL_B = 4;
  typedef enum logic [2:0] {IDLE, LOAD, CALC_START, CALC_WAIT, SWITCH} state_t;
endpackage

// File: rtl/ins_dispatch.sv
// ins_dispatch: in-order dispatcher of host LOAD/CALC/SWITCH instructions; define INS_DISPATCH_PERF_EN for the calc_cycles counter
module ins_dispatch
  import GLOBAL_PARAM::*;
  import INS_CONST::*;
#(
  parameter int PE_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [INST_W-1:0] ins,
  output logic              ld_ins_valid,
  input  logic              ld_ins_ready,
  output logic [INST_W-1:0] ld_ins,
  output logic [PE_NUM-1:0] start,
  input  logic [PE_NUM-1:0] done,
  output logic [2:0]        mode,
  output logic [7:0]        idx_cnt,
  output logic [7:0]        trip_cnt,
  output logic              is_new,
  output logic [3:0]        pad_code,
  output logic              cut_y,
  output logic [PE_NUM-1:0] switch_d,
  output logic [PE_NUM-1:0] switch_p,
  output logic [PE_NUM-1:0] switch_i,
  output logic [PE_NUM-1:0] switch_a,
  output logic              switch_b,
`ifdef INS_DISPATCH_PERF_EN
  output logic [31:0]       calc_cycles,
`endif
  output logic              busy
);
  state_t state, state_nxt;
  logic [PE_NUM-1:0] done_seen;
  logic [OP_W-1:0] op;
  logic acc;
  logic unused_ins;
  assign op = ins[INST_W-1 -: OP_W];
  assign ins_ready = state == IDLE;
  assign busy = state != IDLE;
  assign acc = ins_valid && ins_ready;
  assign unused_ins = ^ins[INST_W-OP_W-1:CUT_BIT+1];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // unknown opcodes are accepted and dropped, leaving the FSM in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = !acc ? IDLE : op == OP_LOAD ? LOAD : op == OP_CALC ? CALC_START : op == OP_SWITCH ? SWITCH : IDLE;
      LOAD:       state_nxt = ld_ins_ready ? IDLE : LOAD;
      CALC_START: state_nxt = CALC_WAIT;
      CALC_WAIT:  state_nxt = &done_seen ? IDLE : CALC_WAIT;
      SWITCH:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ld_ins_valid <= 1'b0;
      ld_ins <= '0;
      start <= '0;
      done_seen <= '0;
      mode <= '0;
      idx_cnt <= '0;
      trip_cnt <= '0;
      is_new <= 1'b0;
      pad_code <= '0;
      cut_y <= 1'b0;
      switch_d <= '0;
      switch_p <= '0;
      switch_i <= '0;
      switch_a <= '0;
      switch_b <= 1'b0;
    end else begin
      start <= '0;
      switch_d <= '0;
      switch_p <= '0;
      switch_i <= '0;
      switch_a <= '0;
      switch_b <= 1'b0;
      done_seen <= done_seen | done;
      if (state == LOAD && ld_ins_ready) ld_ins_valid <= 1'b0;
      if (acc && op == OP_LOAD) begin
        ld_ins_valid <= 1'b1;
        ld_ins <= ins;
      end
      if (acc && op == OP_CALC) begin
        mode <= ins[MODE_LSB +: 3];
        idx_cnt <= ins[IDX_LSB +: 8];
        trip_cnt <= ins[TRIP_LSB +: 8];
        is_new <= ins[NEW_BIT];
        pad_code <= ins[PAD_LSB +: 4];
        cut_y <= ins[CUT_BIT];
        start <= '1;
        done_seen <= '0;
      end
      if (acc && op == OP_SWITCH) begin
        switch_d <= {PE_NUM{ins[SEL_D]}};
        switch_p <= {PE_NUM{ins[SEL_P]}};
        switch_i <= {PE_NUM{ins[SEL_I]}};
        switch_a <= {PE_NUM{ins[SEL_A]}};
        switch_b <= ins[SEL_B];
      end
    end
`ifdef INS_DISPATCH_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) calc_cycles <= '0;
    else if ((state == CALC_START || state == CALC_WAIT) && !(&calc_cycles)) calc_cycles <= calc_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_ins_dispatch.sv
// tb_ins_dispatch: directed stimulus checked every cycle against a transaction-level model plus literal spot checks
module tb_ins_dispatch;
  localparam int PE_NUM = 32;
  localparam logic [PE_NUM-1:0] ALL = '1;
  localparam int K_NONE = 0, K_LOAD = 1, K_CALC = 2, K_SW = 3;
  localparam logic [31:0] W_CALC1 = 32'h2000_2082;
  localparam logic [31:0] W_CALC2 = 32'h21A8_0FFD;
  localparam logic [31:0] W_LD = 32'h1234_5678;
  localparam logic [31:0] W_SW = 32'h3000_0013;
  localparam logic [31:0] W_BAD = 32'hF000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ins_valid, ins_ready, ld_ins_valid, ld_ins_ready;
  logic [31:0] ins, ld_ins;
  logic [PE_NUM-1:0] start, done, switch_d, switch_p, switch_i, switch_a;
  logic [2:0] mode;
  logic [7:0] idx_cnt, trip_cnt;
  logic [3:0] pad_code;
  logic is_new, cut_y, switch_b, busy;
  logic [31:0] calc_cycles;
  int n_cmp = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int m_kind, m_age;
  logic [31:0] m_word, m_cc;
  logic [2:0] m_mode;
  logic [7:0] m_idx, m_trip;
  logic [3:0] m_pad;
  logic m_new, m_cut;
  logic [PE_NUM-1:0] m_seen;
  logic [4:0] sw;

  always #5 clk = ~clk;

  ins_dispatch #(.PE_NUM(PE_NUM)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .ld_ins_valid(ld_ins_valid), .ld_ins_ready(ld_ins_ready), .ld_ins(ld_ins),
    .start(start), .done(done), .mode(mode), .idx_cnt(idx_cnt), .trip_cnt(trip_cnt),
    .is_new(is_new), .pad_code(pad_code), .cut_y(cut_y),
    .switch_d(switch_d), .switch_p(switch_p), .switch_i(switch_i), .switch_a(switch_a),
    .switch_b(switch_b),
`ifdef INS_DISPATCH_PERF_EN
    .calc_cycles(calc_cycles),
`endif
    .busy(busy)
  );
`ifndef INS_DISPATCH_PERF_EN
  assign calc_cycles = '0;
`endif

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // model: one pending transaction with its age since acceptance
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_kind <= K_NONE;
      m_age <= 0;
      m_word <= '0;
      m_cc <= '0;
      m_mode <= '0;
      m_idx <= '0;
      m_trip <= '0;
      m_pad <= '0;
      m_new <= 1'b0;
      m_cut <= 1'b0;
      m_seen <= '0;
    end else begin
      m_age <= m_age + 1;
      if (m_kind == K_CALC && m_cc != 32'hFFFF_FFFF) m_cc <= m_cc + 32'd1;
      case (m_kind)
        K_NONE: if (ins_valid) begin
          m_word <= ins;
          m_age <= 1;
          case (ins[31:28])
            4'd1: m_kind <= K_LOAD;
            4'd2: begin
              m_kind <= K_CALC;
              m_mode <= ins[2:0];
              m_idx <= ins[10:3];
              m_trip <= ins[18:11];
              m_new <= ins[19];
              m_pad <= ins[23:20];
              m_cut <= ins[24];
              m_seen <= '0;
            end
            4'd3: m_kind <= K_SW;
            default: m_kind <= K_NONE;
          endcase
        end
        K_LOAD: if (ld_ins_ready) m_kind <= K_NONE;
        K_CALC: if (&m_seen) m_kind <= K_NONE; else m_seen <= m_seen | done;
        default: m_kind <= K_NONE;
      endcase
    end

  always @(negedge clk)
    if (chk_en) begin
      sw = m_kind == K_SW ? m_word[4:0] : 5'd0;
      check("ins_ready", 64'(ins_ready), 64'(m_kind == K_NONE));
      check("busy", 64'(busy), 64'(m_kind != K_NONE));
      check("ld_ins_valid", 64'(ld_ins_valid), 64'(m_kind == K_LOAD));
      if (m_kind == K_LOAD) check("ld_ins", 64'(ld_ins), 64'(m_word));
      check("start", 64'(start), (m_kind == K_CALC && m_age == 1) ? 64'(ALL) : 64'd0);
      check("switch_d", 64'(switch_d), 64'({PE_NUM{sw[0]}}));
      check("switch_p", 64'(switch_p), 64'({PE_NUM{sw[1]}}));
      check("switch_i", 64'(switch_i), 64'({PE_NUM{sw[2]}}));
      check("switch_a", 64'(switch_a), 64'({PE_NUM{sw[3]}}));
      check("switch_b", 64'(switch_b), 64'(sw[4]));
      check("calc_fields", {mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y}, {m_mode, m_idx, m_trip, m_new, m_pad, m_cut});
`ifdef INS_DISPATCH_PERF_EN
      check("calc_cycles", 64'(calc_cycles), 64'(m_cc));
`endif
    end

  task automatic issue(input logic [31:0] w);
    ins_valid = 1'b1;
    ins = w;
    tick;
    ins_valid = 1'b0;
  endtask

  initial begin
    ins_valid = 1'b0;
    ins = '0;
    ld_ins_ready = 1'b0;
    done = '0;
    repeat (2) tick;
    check("rst_outputs", {start, switch_d, 4'(ld_ins_valid), 4'(busy), 4'(switch_b)}, 64'd0);
    check("rst_fields_ld", {mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y, ld_ins}, 64'd0);
    check("rst_ins_ready", 64'(ins_ready), 64'd1);
    rst = 1'b0;
    chk_en = 1'b1;
    tick;
    issue(W_CALC1);
    check("calc1_start_c1", 64'(start), 64'(ALL));
    check("calc1_fields", {mode, idx_cnt, trip_cnt}, {3'd2, 8'd16, 8'd4});
    tick;
    check("calc1_start_c2", 64'(start), 64'd0);
    repeat (2) tick;
    for (int c = 5; c <= 36; c++) begin
      tick;
      done = PE_NUM'(1) << (c - 5);
    end
    tick;
    done = '0;
    check("calc1_ready_c37", 64'(ins_ready), 64'd0);
    tick;
    check("calc1_ready_c38", 64'(ins_ready), 64'd1);
`ifdef INS_DISPATCH_PERF_EN
    check("calc1_cycles", 64'(calc_cycles), 64'd37);
`endif
    issue(W_LD);
    check("load_valid_c1", {31'd0, ld_ins_valid, ld_ins}, {31'd0, 1'b1, W_LD});
    repeat (2) tick;
    check("load_hold_c3", {31'd0, ld_ins_valid, ld_ins}, {31'd0, 1'b1, W_LD});
    tick;
    ld_ins_ready = 1'b1;
    check("load_valid_c4", 64'(ld_ins_valid), 64'd1);
    tick;
    ld_ins_ready = 1'b0;
    check("load_done_c5", {ld_ins_valid, ins_ready}, 64'b01);
    issue(W_SW);
    check("sw_c1", {switch_d, switch_p}, {ALL, ALL});
    check("sw_c1_ia_b", {switch_i, switch_a, 4'(switch_b)}, 64'd1);
    tick;
    check("sw_c2", {switch_d[0], switch_p[0], switch_b, ins_ready}, 64'b0001);
    issue(W_CALC2);
    ins_valid = 1'b1;
    ins = W_SW;
    check("calc2_fields", {mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y}, {3'd5, 8'hFF, 8'h01, 1'b1, 4'hA, 1'b1});
    repeat (2) tick;
    done = ALL;
    tick;
    done = '0;
    check("calc2_blocked_c4", {31'd0, ins_ready, switch_d}, 64'd0);
    tick;
    check("calc2_ready_c5", 64'(ins_ready), 64'd1);
    tick;
    ins_valid = 1'b0;
    check("sw_after_calc_c6", {31'd0, switch_b, switch_d}, {31'd0, 1'b1, ALL});
    tick;
    issue(W_BAD);
    check("bad_dropped", {ins_ready, busy, mode}, {1'b1, 1'b0, 3'd5});
    issue(W_CALC1);
    tick;
    done = 32'h0000_FFFF;
    tick;
    rst = 1'b1;
    #1;
    check("rst_calc_wait", {busy, ins_ready, mode, idx_cnt, trip_cnt}, {1'b0, 1'b1, 19'd0});
    check("rst_calc_start", 64'(start), 64'd0);
    tick;
    rst = 1'b0;
    done = '0;
    issue(W_LD);
    tick;
    rst = 1'b1;
    #1;
    check("rst_load", {31'd0, ld_ins_valid, ld_ins}, 64'd0);
    check("rst_load_busy", {busy, ins_ready}, 64'b01);
    tick;
    rst = 1'b0;
    issue(W_CALC1);
    repeat (30) tick;
    done = ALL;
    tick;
    done = '0;
    tick;
    check("calc31_ready", 64'(ins_ready), 64'd1);
`ifdef INS_DISPATCH_PERF_EN
    check("calc31_cycles", 64'(calc_cycles), 64'd32);
`endif
    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ins_dispatch.md
INS_DISPATCH -- requirements
Module: ins_dispatch

Interface
REQ-001 SHALL have parameter PE_NUM, default 32, number of PEs driven by start/done/switch vectors.
REQ-002 SHALL have ports: clk input 1 clock; rst input 1 reset; one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports: ins_valid input 1; ins_ready output 1; ins input INST_W, the host instruction stream.
REQ-004 SHALL have ports: ld_ins_valid output 1; ld_ins_ready input 1; ld_ins output INST_W, the load instruction to the DDR-to-PE loader.
REQ-005 SHALL have ports: start output PE_NUM; done input PE_NUM; mode output 3; idx_cnt output 8; trip_cnt output 8; is_new output 1; pad_code output 4; cut_y output 1, the PE-array calc control.
REQ-006 SHALL have ports: switch_d, switch_p, switch_i, switch_a output PE_NUM; switch_b output 1, the ping-pong buffer swap pulses.
REQ-007 SHALL have port busy output 1, high whenever state is not IDLE.

Function
REQ-008 SHALL decode opcode ins[INST_W-1 -: 4]: OP_LOAD, OP_CALC, OP_SWITCH; all other codes SHALL be consumed and dropped.
REQ-009 SHALL implement FSM states IDLE, LOAD, CALC_START, CALC_WAIT, SWITCH.
REQ-010 SHALL drive ins_ready high only in IDLE; an instruction is accepted on cycle N when ins_valid && ins_ready, and is registered.
REQ-011 SHALL leave IDLE on acceptance: OP_LOAD->LOAD, OP_CALC->CALC_START, OP_SWITCH->SWITCH, other->IDLE (ins_ready stays high at N+1).
REQ-012 LOAD: ld_ins_valid SHALL rise at N+1 with ld_ins equal to the accepted word, held stable until ld_ins_ready; return to IDLE the cycle after the handshake.
REQ-013 CALC_START: SHALL load mode=ins[2:0], idx_cnt=ins[10:3], trip_cnt=ins[18:11], is_new=ins[19], pad_code=ins[23:20], cut_y=ins[24] at N+1, and assert start all-ones for exactly one cycle (N+1), then go to CALC_WAIT.
REQ-014 Calc fields SHALL stay stable from N+1 until the next OP_CALC is accepted.
REQ-015 CALC_WAIT: SHALL keep a PE_NUM-bit sticky done_seen register, OR-ing in done each cycle; done bits arriving in the start cycle SHALL be counted.
REQ-016 SHALL return to IDLE the cycle after done_seen becomes all-ones, and clear done_seen on entry to CALC_START.
REQ-017 SWITCH: SHALL pulse for one cycle (N+1) switch_d/p/i/a replicated to all PE bits and switch_b, each gated by select bits ins[0..4] respectively; return to IDLE at N+2.
REQ-018 All start/switch/ld outputs SHALL be registered; no combinational path from done, ins or ld_ins_ready to any output except ins_ready (state-derived only).
REQ-019 Instructions SHALL execute strictly in order; a SWITCH or LOAD behind an OP_CALC SHALL NOT be accepted until that calc completes.

Reset
REQ-020 SHALL on rst go to IDLE asynchronously with start, all switch_*, ld_ins_valid, busy, done_seen, mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y, ld_ins all zero.
REQ-021 Reset mid-LOAD SHALL drop ld_ins_valid immediately without completing the handshake; mid-CALC_WAIT SHALL abandon the wait.

Configuration
REQ-022 With macro INS_DISPATCH_PERF_EN defined, SHALL add output calc_cycles (32 bits) counting cycles spent in CALC_START+CALC_WAIT, saturating at all-ones, cleared by reset only; without it, the port and counter SHALL not exist.

Structure
REQ-023 Opcode constants OP_LOAD=1, OP_CALC=2, OP_SWITCH=3, the field bit positions and the FSM state enum SHALL live in package INS_CONST; INST_W from GLOBAL_PARAM.
REQ-024 SHALL be a single module with no sub-modules.

Verification
REQ-025 OP_CALC mode=2, idx_cnt=16, trip_cnt=4 at cycle 0 -> start=all-ones only at cycle 1, fields valid at 1; done pulsed PE by PE over cycles 5..36 -> ins_ready high at cycle 38.
REQ-026 OP_LOAD with ld_ins_ready low for 3 cycles -> ld_ins_valid high cycles 1..4, ld_ins stable, ins_ready high at cycle 5.
REQ-027 OP_SWITCH select=5'b10011 -> switch_d, switch_p, switch_b pulse one cycle at cycle 1, switch_i/a stay 0; ins_ready back at cycle 2.
REQ-028 OP_CALC followed immediately by OP_SWITCH -> ins_ready low until all done seen, no switch pulse before calc completes; unknown opcode 4'hF -> dropped, ins_ready high next cycle.
REQ-029 rst asserted during CALC_WAIT and during LOAD stall -> all outputs zero same cycle, FSM IDLE; with INS_DISPATCH_PERF_EN, calc_cycles equals calc duration (32 for a 31-cycle wait).
